// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: width helpers, control bundles and saturation constants for the MAC slice
package dsp_mac_pkg;
   localparam int SATW = 128;
   typedef struct packed {
      logic pre_en;
      logic pre_sub;
   } pre_t;
   typedef struct packed {
      logic load;
      logic acc_sub;
   } ctl_t;
   function automatic int max(input int a, input int b);
      return a > b ? a : b;
   endfunction
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
   function automatic int prew(input int bw, input int dw);
      return max(bw, dw) + 1;
   endfunction
   function automatic int mw(input int aw, input int bw, input int dw);
      return aw + prew(bw, dw);
   endfunction
   function automatic int chw(input int nch);
      return max(1, clog2(nch));
   endfunction
   function automatic logic [SATW-1:0] sat_min(input int pw);
      return SATW'(1) << (pw - 1);
   endfunction
   function automatic logic [SATW-1:0] sat_max(input int pw);
      return sat_min(pw) - SATW'(1);
   endfunction
endpackage

// File: rtl/dsp_acc_bank.sv
// dsp_acc_bank: per-channel accumulator registers with one read port, one write port and bulk clear
module dsp_acc_bank
   import dsp_mac_pkg::*;
#(
   parameter int PW  = 48,
   parameter int NCH = 4,
   parameter int CHW = chw(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           clr,
   input  logic           we,
   input  logic [CHW-1:0] wa,
   input  logic [PW-1:0]  wd,
   input  logic [CHW-1:0] ra,
   output logic [PW-1:0]  rd
);
   logic [PW-1:0] mem_q [NCH];
   logic [PW-1:0] mem_d [NCH];
   always_comb begin
      for (int i = 0; i < NCH; i++) mem_d[i] = clr ? '0 : (we && wa == CHW'(i)) ? wd : mem_q[i];
   end
   always_ff @(posedge clk) begin
      if (rst) mem_q <= '{default: '0};
      else if (en) mem_q <= mem_d;
   end
   assign rd = mem_q[ra];
endmodule

// File: rtl/dsp_mac_acc.sv
// dsp_mac_acc: pipelined signed pre-add/multiply/accumulate slice with a per-channel accumulator bank
module dsp_mac_acc
   import dsp_mac_pkg::*;
#(
   parameter int AW  = 18,
   parameter int BW  = 18,
   parameter int DW  = 18,
   parameter int PW  = 48,
   parameter int NCH = 4,
   parameter bit SAT = 1'b1,
   localparam int CHW = chw(NCH)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic                 CLR,
   input  logic                 IN_VALID,
   input  logic [CHW-1:0]       IN_CH,
   input  logic signed [AW-1:0] A,
   input  logic signed [BW-1:0] B,
   input  logic signed [DW-1:0] D,
   input  logic signed [PW-1:0] C,
   input  logic                 PRE_EN,
   input  logic                 PRE_SUB,
   input  logic                 LOAD,
   input  logic                 ACC_SUB,
   output logic                 OUT_VALID,
   output logic [CHW-1:0]       OUT_CH,
   output logic signed [PW-1:0] P,
   output logic                 OVF
);
   localparam int PREW = prew(BW, DW);
   localparam int MW = mw(AW, BW, DW);
   localparam logic [PW-1:0] SMAX = PW'(sat_max(PW));
   localparam logic [PW-1:0] SMIN = PW'(sat_min(PW));
   // beat tag that travels unchanged alongside the datapath until the accumulate stage
   typedef struct packed {
      logic                 v;
      logic [CHW-1:0]       ch;
      ctl_t                 ctl;
      logic signed [PW-1:0] c;
   } tag_t;
   tag_t tag_q [4];
   tag_t tag_d [4];
   pre_t pre1_q, pre1_d;
   logic signed [AW-1:0] a1_q, a1_d, a2_q, a2_d;
   logic signed [BW-1:0] b1_q, b1_d;
   logic signed [DW-1:0] d1_q, d1_d;
   logic signed [PREW-1:0] x2_q, x2_d;
   logic signed [MW-1:0] m3_q, m3_d;
   logic signed [PW-1:0] m4_q, m4_d, p_q, p_d, base, res;
   logic [PW-1:0] bank_rd;
   logic signed [PW:0] sum;
   logic ov_q, ov_d, ovf_q, ovf_d, hit;
   logic [CHW-1:0] och_q, och_d;
   always_comb begin
      tag_d[0] = '{v: IN_VALID, ch: IN_CH, ctl: '{load: LOAD, acc_sub: ACC_SUB}, c: C};
      for (int i = 1; i < 4; i++) tag_d[i] = tag_q[i-1];
      pre1_d = '{pre_en: PRE_EN, pre_sub: PRE_SUB};
      a1_d = A;
      b1_d = B;
      d1_d = D;
      a2_d = a1_q;
      x2_d = !pre1_q.pre_en ? PREW'(b1_q) :
             pre1_q.pre_sub ? PREW'(d1_q) - PREW'(b1_q) : PREW'(d1_q) + PREW'(b1_q);
      m3_d = MW'(a2_q) * MW'(x2_q);
      m4_d = PW'(m3_q);
      base = tag_q[3].ctl.load ? tag_q[3].c : bank_rd;
      sum = tag_q[3].ctl.acc_sub ? (PW+1)'(base) - (PW+1)'(m4_q) : (PW+1)'(base) + (PW+1)'(m4_q);
      hit = sum[PW] != sum[PW-1];
      res = (SAT && hit) ? (sum[PW] ? SMIN : SMAX) : sum[PW-1:0];
      ov_d = tag_q[3].v;
      p_d = ov_d ? res : p_q;
      och_d = ov_d ? tag_q[3].ch : och_q;
      ovf_d = ov_d ? hit : ovf_q;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 4; i++) tag_q[i].v <= 1'b0;
         ov_q <= 1'b0;
         och_q <= '0;
         p_q <= '0;
         ovf_q <= 1'b0;
      end else if (EN) begin
         tag_q <= tag_d;
         ov_q <= ov_d;
         och_q <= och_d;
         p_q <= p_d;
         ovf_q <= ovf_d;
      end
   end
   always_ff @(posedge CLK) begin
      if (EN) begin
         pre1_q <= pre1_d;
         a1_q <= a1_d;
         b1_q <= b1_d;
         d1_q <= d1_d;
         a2_q <= a2_d;
         x2_q <= x2_d;
         m3_q <= m3_d;
         m4_q <= m4_d;
      end
   end
   // read and write share the S4 channel, so the next beat always sees this beat's update
   dsp_acc_bank #(.PW(PW), .NCH(NCH), .CHW(CHW)) u_bank (
      .clk(CLK),
      .rst(RST),
      .en(EN),
      .clr(CLR),
      .we(tag_q[3].v),
      .wa(tag_q[3].ch),
      .wd(res),
      .ra(tag_q[3].ch),
      .rd(bank_rd)
   );
   assign OUT_VALID = ov_q;
   assign OUT_CH = och_q;
   assign P = p_q;
   assign OVF = ovf_q;
endmodule

// File: tb/tb_dsp_mac_acc.sv
// tb_dsp_mac_acc: scoreboard bench driving default, saturating and wrapping dsp_mac_acc instances
module tb_dsp_mac_acc;
   typedef struct {
      int stamp;
      longint a, b, d, c;
      int ch;
      bit pre_en, pre_sub, load, acc_sub;
   } beat_t;
   typedef struct {
      longint p;
      int ch;
      bit ovf;
      int edge_n;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, clr = 1'b0, in_valid = 1'b0;
   logic [1:0] in_ch = '0;
   logic [17:0] a = '0, b = '0, d = '0;
   logic [47:0] c = '0;
   logic pre_en = 1'b0, pre_sub = 1'b0, load = 1'b0, acc_sub = 1'b0;
   logic ov [3];
   logic [1:0] och [3];
   logic ovf [3];
   logic [47:0] p0;
   logic [19:0] p1, p2;
   int aw_c [3] = '{18, 8, 8};
   int pw_c [3] = '{48, 20, 20};
   bit sat_c [3] = '{1'b1, 1'b1, 1'b0};
   longint bank [3][4];
   logic signed [63:0] lastp [3][4];
   logic lastovf [3][4];
   logic signed [63:0] last [3];
   logic ov_prev [3];
   beat_t pend [$];
   exp_t sb [3][$];
   int checks = 0, errors = 0, edge_n = 0, ecnt = 0;
   bit en_edge = 1'b0, rst_edge = 1'b0;
   always #5 clk = ~clk;
   dsp_mac_acc u0 (
      .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .IN_VALID(in_valid), .IN_CH(in_ch),
      .A(a), .B(b), .D(d), .C(c), .PRE_EN(pre_en), .PRE_SUB(pre_sub), .LOAD(load), .ACC_SUB(acc_sub),
      .OUT_VALID(ov[0]), .OUT_CH(och[0]), .P(p0), .OVF(ovf[0])
   );
   dsp_mac_acc #(.AW(8), .BW(8), .DW(8), .PW(20), .SAT(1'b1)) u1 (
      .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .IN_VALID(in_valid), .IN_CH(in_ch),
      .A(a[7:0]), .B(b[7:0]), .D(d[7:0]), .C(c[19:0]), .PRE_EN(pre_en), .PRE_SUB(pre_sub), .LOAD(load), .ACC_SUB(acc_sub),
      .OUT_VALID(ov[1]), .OUT_CH(och[1]), .P(p1), .OVF(ovf[1])
   );
   dsp_mac_acc #(.AW(8), .BW(8), .DW(8), .PW(20), .SAT(1'b0)) u2 (
      .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .IN_VALID(in_valid), .IN_CH(in_ch),
      .A(a[7:0]), .B(b[7:0]), .D(d[7:0]), .C(c[19:0]), .PRE_EN(pre_en), .PRE_SUB(pre_sub), .LOAD(load), .ACC_SUB(acc_sub),
      .OUT_VALID(ov[2]), .OUT_CH(och[2]), .P(p2), .OVF(ovf[2])
   );
   function automatic longint sx(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction
   task automatic chk(input string nm, input int k, input logic signed [63:0] act, input logic signed [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d got %0d expected %0d", nm, k, act, expv);
      end
   endtask
   // reference: a beat's effect lands four enabled edges after it was accepted
   function automatic void apply(input beat_t t);
      longint av, bv, dv, cv, x, m, base, s, hi, lo, r;
      bit o;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         av = sx(t.a, aw_c[k]);
         bv = sx(t.b, aw_c[k]);
         dv = sx(t.d, aw_c[k]);
         cv = sx(t.c, pw_c[k]);
         x = t.pre_en ? (t.pre_sub ? dv - bv : dv + bv) : bv;
         m = av * x;
         base = t.load ? cv : bank[k][t.ch];
         s = t.acc_sub ? base - m : base + m;
         hi = (longint'(1) <<< (pw_c[k] - 1)) - 1;
         lo = -hi - 1;
         o = s > hi || s < lo;
         r = !o ? s : sat_c[k] ? (s > hi ? hi : lo) : sx(s, pw_c[k]);
         bank[k][t.ch] = r;
         e.p = r;
         e.ch = t.ch;
         e.ovf = o;
         e.edge_n = edge_n;
         sb[k].push_back(e);
      end
   endfunction
   initial forever begin
      beat_t t;
      @(posedge clk);
      edge_n++;
      rst_edge = rst;
      en_edge = en;
      if (rst) begin
         pend.delete();
         for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            for (int j = 0; j < 4; j++) bank[k][j] = 0;
         end
      end else if (en) begin
         ecnt++;
         if (in_valid) begin
            t.stamp = ecnt;
            t.a = longint'(a);
            t.b = longint'(b);
            t.d = longint'(d);
            t.c = longint'(c);
            t.ch = int'(in_ch);
            t.pre_en = pre_en;
            t.pre_sub = pre_sub;
            t.load = load;
            t.acc_sub = acc_sub;
            pend.push_back(t);
         end
         while (pend.size() > 0 && pend[0].stamp == ecnt - 4) apply(pend.pop_front());
         if (clr) for (int k = 0; k < 3; k++) for (int j = 0; j < 4; j++) bank[k][j] = 0;
      end
   end
   initial forever begin
      logic signed [63:0] pk;
      exp_t e;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         pk = k == 0 ? $signed(p0) : k == 1 ? $signed(p1) : $signed(p2);
         if (rst_edge) begin
            chk("rst_valid", k, 64'(ov[k]), 64'sd0);
            chk("rst_p", k, pk, 64'sd0);
            last[k] = 0;
         end else if (!en_edge) begin
            chk("stall_valid", k, 64'(ov[k]), 64'(ov_prev[k]));
            chk("stall_p", k, pk, last[k]);
         end else if (ov[k] === 1'b1) begin
            if (sb[k].size() == 0 || sb[k][0].edge_n > edge_n) chk("unexpected_valid", k, 64'(ov[k]), 64'sd0);
            else begin
               e = sb[k].pop_front();
               chk("p", k, pk, e.p);
               chk("out_ch", k, 64'(och[k]), 64'(e.ch));
               chk("ovf", k, 64'(ovf[k]), 64'(e.ovf));
               last[k] = pk;
               lastp[k][e.ch] = pk;
               lastovf[k][e.ch] = ovf[k];
            end
         end else begin
            if (sb[k].size() > 0 && sb[k][0].edge_n <= edge_n) begin
               chk("missing_valid", k, 64'(ov[k]), 64'sd1);
               void'(sb[k].pop_front());
            end
            chk("hold_p", k, pk, last[k]);
         end
         ov_prev[k] = ov[k];
      end
   end
   task automatic beat(input int ch, input longint av, input longint bv, input longint dv, input longint cv,
                       input bit pe, input bit ps, input bit ld, input bit sub);
      @(negedge clk);
      en = 1'b1;
      clr = 1'b0;
      in_valid = 1'b1;
      in_ch = 2'(ch);
      a = 18'(av);
      b = 18'(bv);
      d = 18'(dv);
      c = 48'(cv);
      pre_en = pe;
      pre_sub = ps;
      load = ld;
      acc_sub = sub;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         en = 1'b1;
         clr = 1'b0;
         in_valid = 1'b0;
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      beat(0, 3, 4, 0, 0, 0, 0, 1, 0);
      beat(0, 2, 5, 0, 0, 0, 0, 0, 0);
      idle(6);
      chk("basic_p", 0, lastp[0][0], 64'sd22);
      chk("basic_ovf", 0, 64'(lastovf[0][0]), 64'sd0);
      beat(1, -2, 3, 10, 100, 1, 1, 1, 0);
      beat(2, 1, -131072, -131072, 0, 1, 0, 1, 0);
      idle(6);
      chk("presub_p", 0, lastp[0][1], 64'sd86);
      chk("preadd_wide_p", 0, lastp[0][2], -64'sd262144);
      for (int ch = 0; ch < 4; ch++) beat(ch, 0, 0, 0, ch * 1000, 0, 0, 1, 0);
      for (int r = 0; r < 3; r++) for (int ch = 0; ch < 4; ch++) beat(ch, 1, ch + 1, 0, 0, 0, 0, 0, 0);
      idle(6);
      for (int ch = 0; ch < 4; ch++) chk("interleave_p", 0, lastp[0][ch], 64'(ch * 1000 + 3 * (ch + 1)));
      beat(3, 0, 0, 0, 524287, 0, 0, 1, 0);
      beat(3, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(6);
      chk("sat_p", 1, lastp[1][3], 64'sd524287);
      chk("sat_ovf", 1, 64'(lastovf[1][3]), 64'sd1);
      chk("wrap_p", 2, lastp[2][3], -64'sd524288);
      chk("wrap_ovf", 2, 64'(lastovf[2][3]), 64'sd1);
      beat(3, 1, 1, 0, 0, 0, 0, 0, 1);
      idle(6);
      chk("sat_sub_p", 1, lastp[1][3], 64'sd524286);
      chk("sat_sub_ovf", 1, 64'(lastovf[1][3]), 64'sd0);
      for (int i = 0; i < 6; i++) begin
         if (i == 3) repeat (3) begin
            @(negedge clk);
            en = 1'b0;
            in_valid = 1'b1;
            a = 18'd77;
         end
         beat(i % 4, i + 1, 2, 0, 0, 0, 0, 0, 0);
      end
      idle(6);
      beat(1, 1, 1, 0, 50, 0, 0, 1, 0);
      idle(3);
      @(negedge clk);
      in_valid = 1'b0;
      clr = 1'b1;
      beat(1, 1, 5, 0, 0, 0, 0, 0, 0);
      idle(6);
      chk("clr_then_add_p", 0, lastp[0][1], 64'sd5);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         en = $urandom_range(9) != 0;
         clr = $urandom_range(29) == 0;
         in_valid = $urandom_range(3) != 0;
         in_ch = 2'($urandom_range(3));
         a = 18'($urandom);
         b = 18'($urandom);
         d = 18'($urandom);
         c = 48'({$urandom, $urandom});
         pre_en = 1'($urandom);
         pre_sub = 1'($urandom);
         load = $urandom_range(3) == 0;
         acc_sub = 1'($urandom);
      end
      idle(6);
      for (int ch = 0; ch < 3; ch++) beat(ch, 5, 5, 0, 11, 0, 0, 1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      beat(0, 1, 7, 0, 0, 0, 0, 0, 0);
      idle(8);
      chk("post_reset_p", 0, lastp[0][0], 64'sd7);
      for (int k = 0; k < 3; k++) chk("drain", k, 64'(sb[k].size()), 64'sd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
